uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_rx_fifo.sv | 38 +++
 rtl/uart_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, data width and bit-timing helper
package uart_pkg;
  localparam int DataWidth = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} uart_rx_state_e;
  function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO with wrap-bit pointers
module uart_rx_fifo #(
  parameter int Depth = 4,
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // advance pointers on accepted push/pop; a pop frees room for a same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end
  // storage write, no reset needed since dout is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with FWFT byte FIFO and error pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate = 115_200,
  parameter int FifoDepth = 4
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_i,
  input  logic                 uart_rx_i,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overflow_o,
  output logic                 busy_o
);
  localparam int ClocksPerBit = clocks_per_bit(ClockFrequency, BaudRate);
  localparam int CntW = $clog2(ClocksPerBit);
  localparam int IdxW = $clog2(DataWidth);
  localparam logic [CntW-1:0] HalfLoad = CntW'(ClocksPerBit / 2 - 1);
  localparam logic [CntW-1:0] BitLoad = CntW'(ClocksPerBit - 1);
  logic [1:0] sync_q;
  logic rx_s, tick, push, pop, full, empty, frame_err_d;
  uart_rx_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [DataWidth-1:0] shift_q, shift_d;
  assign rx_s = sync_q[1];
  assign tick = cnt_q == '0;
  assign pop = rx_valid_o && rx_ready_i;
  assign rx_valid_o = !empty;
  assign busy_o = state_q != IDLE;
  // two-flop synchronizer, idle-high after reset
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], uart_rx_i};
  end
  // frame sequencing: sample mid-bit whenever the counter expires
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? BitLoad : cnt_q - 1'b1;
    idx_d = idx_q;
    shift_d = shift_q;
    push = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = rx_s ? '0 : HalfLoad;
        state_d = rx_s ? IDLE : START;
      end
      START: if (tick) begin
        state_d = rx_s ? IDLE : DATA;
        idx_d = '0;
      end
      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[DataWidth-1:1]};
        idx_d = idx_q + 1'b1;
        state_d = idx_q == IdxW'(DataWidth - 1) ? STOP : DATA;
      end
      STOP: if (tick) begin
        push = rx_s;
        frame_err_d = !rx_s;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: state_d = rx_s ? IDLE : WAIT_IDLE;
      default: state_d = IDLE;
    endcase
  end
  // FSM/datapath registers and registered one-cycle status pulses
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      frame_err_o <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      frame_err_o <= frame_err_d;
      overflow_o <= push && full && !pop;
    end
  end
  uart_rx_fifo #(.Depth(FifoDepth), .Width(DataWidth)) u_fifo (
    .clk(clk_sys_i),
    .rst(rst_sys_i),
    .push(push),
    .pop(pop),
    .din(shift_q),
    .dout(rx_data_o),
    .full(full),
    .empty(empty)
  );
endmodule
